emif_intf_param: RTL and testbench

EMIF_INTF_PARAM -- requirements
Module: emif_intf_param

---
 rtl/emif_intf_param.sv | 339 +++++++++++++++++++++++++++++++++
 tb/tb_emif_intf_param.sv | 467 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/emif_intf_param.sv
// -----------------------------------------------------------------------------
// emif_intf_param
//
// Bridges an asynchronous EMIF slave port onto a synchronous dual-port RAM
// interface in the clk_100m domain. Every EMIF input is passed through a
// synchroniser. Falling edges of the write and output enables are detected on
// the synchronised strobes. After a programmable settle delay, the bridge
// issues a single-cycle DPRAM write or read strobe. Read data is returned
// on emif_data_o while the host keeps its output enable asserted.
//
// Ports
//   clk_100m      system clock
//   rst_n         asynchronous active-low reset
//   emif_data_i   EMIF write data (DW)
//   emif_addr_i   EMIF address (AW)
//   emif_byten_i  EMIF byte enables, active-low (DW/8)
//   emif_cen_i    chip enable, active-low
//   emif_wen_i    write enable, active-low
//   emif_oen_i    output enable, active-low
//   emif_data_o   read data returned to EMIF (DW)
//   emif_data_oe  read-data drive enable, active-high
//   dpram_wen     single-cycle DPRAM write strobe
//   dpram_ren     single-cycle DPRAM read strobe
//   dpram_addr    DPRAM access address (AW)
//   dpram_wdata   DPRAM write data (DW)
//   dpram_be      DPRAM byte mask, active-high (DW/8)
//   dpram_rdata   DPRAM read data (DW)
//   dpram_rvalid  DPRAM read data valid
//   err_pulse     one-cycle protocol or read-timeout error
// -----------------------------------------------------------------------------
module emif_intf_param #(
  parameter int DW          = 16,
  parameter int AW          = 24,
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE      = 1,
  parameter int ADDR_ROT    = 1,
  parameter int RD_TIMEOUT  = 15
) (
  input  logic            clk_100m,
  input  logic            rst_n,
  input  logic [DW-1:0]   emif_data_i,
  input  logic [AW-1:0]   emif_addr_i,
  input  logic [DW/8-1:0] emif_byten_i,
  input  logic            emif_cen_i,
  input  logic            emif_wen_i,
  input  logic            emif_oen_i,
  output logic [DW-1:0]   emif_data_o,
  output logic            emif_data_oe,
  output logic            dpram_wen,
  output logic            dpram_ren,
  output logic [AW-1:0]   dpram_addr,
  output logic [DW-1:0]   dpram_wdata,
  output logic [DW/8-1:0] dpram_be,
  input  logic [DW-1:0]   dpram_rdata,
  input  logic            dpram_rvalid,
  output logic            err_pulse
);

  localparam int BW = DW / 8;
  localparam logic [2:0] SETTLE_LAST = (SETTLE > 0) ? 3'(SETTLE - 1) : 3'd0;
  localparam logic [7:0] TO_LIMIT    = 8'(RD_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    WR_SETTLE,
    WR_ISSUE,
    RD_SETTLE,
    RD_ISSUE,
    RD_WAIT,
    RD_DRIVE,
    WAIT_CEN
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // Synchroniser chains; the control bundle is ordered {cen, wen, oen}
  logic [SYNC_STAGES-1:0][DW-1:0] r_data_sync;
  logic [SYNC_STAGES-1:0][AW-1:0] r_addr_sync;
  logic [SYNC_STAGES-1:0][BW-1:0] r_byten_sync;
  logic [SYNC_STAGES-1:0][2:0]    r_ctl_sync;

  logic [DW-1:0] w_data_s;
  logic [AW-1:0] w_addr_s;
  logic [AW-1:0] w_addr_map;
  logic [BW-1:0] w_byten_s;
  logic          w_cen_s;
  logic          w_wen_s;
  logic          w_oen_s;

  logic r_wen_d;
  logic r_oen_d;
  logic w_wen_fall;
  logic w_oen_fall;
  logic w_wr_cond;
  logic w_rd_cond;
  logic w_byten_bad;
  logic r_wr_start;
  logic r_rd_start;
  logic r_err_start;

  logic [2:0] r_settle_cnt;
  logic [7:0] r_to_cnt;
  logic       w_timeout;

  logic          r_dpram_wen;
  logic          r_dpram_ren;
  logic [AW-1:0] r_dpram_addr;
  logic [DW-1:0] r_dpram_wdata;
  logic [BW-1:0] r_dpram_be;
  logic [DW-1:0] r_emif_data_o;
  logic          r_emif_data_oe;
  logic          r_err_pulse;

  logic          w_dpram_wen;
  logic          w_dpram_ren;
  logic [AW-1:0] w_dpram_addr;
  logic [DW-1:0] w_dpram_wdata;
  logic [BW-1:0] w_dpram_be;
  logic [DW-1:0] w_emif_data_o;
  logic          w_emif_data_oe;
  logic          w_err_pulse;

  // Input synchronisers; reset to the idle bus state so no edge is seen
  // when reset is released
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      r_data_sync  <= '0;
      r_addr_sync  <= '0;
      r_byten_sync <= '1;
      r_ctl_sync   <= '1;
    end else begin
      r_data_sync[0]  <= emif_data_i;
      r_addr_sync[0]  <= emif_addr_i;
      r_byten_sync[0] <= emif_byten_i;
      r_ctl_sync[0]   <= {emif_cen_i, emif_wen_i, emif_oen_i};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_data_sync[i]  <= r_data_sync[i-1];
        r_addr_sync[i]  <= r_addr_sync[i-1];
        r_byten_sync[i] <= r_byten_sync[i-1];
        r_ctl_sync[i]   <= r_ctl_sync[i-1];
      end
    end
  end

  assign w_data_s  = r_data_sync[SYNC_STAGES-1];
  assign w_addr_s  = r_addr_sync[SYNC_STAGES-1];
  assign w_byten_s = r_byten_sync[SYNC_STAGES-1];
  assign w_cen_s   = r_ctl_sync[SYNC_STAGES-1][2];
  assign w_wen_s   = r_ctl_sync[SYNC_STAGES-1][1];
  assign w_oen_s   = r_ctl_sync[SYNC_STAGES-1][0];

  assign w_addr_map = (ADDR_ROT != 0) ? {w_addr_s[AW-2:0], w_addr_s[AW-1]} : w_addr_s;

  assign w_wen_fall  = r_wen_d & ~w_wen_s;
  assign w_oen_fall  = r_oen_d & ~w_oen_s;
  assign w_wr_cond   = w_wen_fall & ~w_cen_s & w_oen_s;
  assign w_rd_cond   = w_oen_fall & ~w_cen_s & w_wen_s;
  assign w_byten_bad = &w_byten_s;
  assign w_timeout   = (r_to_cnt == TO_LIMIT);

  // Start detection is registered, giving one extra stage that sets the
  // fixed strobe latency relative to the EMIF edge
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      r_wen_d     <= 1'b1;
      r_oen_d     <= 1'b1;
      r_wr_start  <= 1'b0;
      r_rd_start  <= 1'b0;
      r_err_start <= 1'b0;
    end else begin
      r_wen_d     <= w_wen_s;
      r_oen_d     <= w_oen_s;
      r_wr_start  <= w_wr_cond & ~w_byten_bad;
      r_rd_start  <= w_rd_cond & ~w_byten_bad;
      r_err_start <= (w_wen_fall & w_oen_fall & ~w_cen_s) |
                     ((w_wr_cond | w_rd_cond) & w_byten_bad);
    end
  end

  // State register
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; cen released in a settle or wait state abandons the access
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (r_err_start) begin
          w_next_state = WAIT_CEN;
        end else if (r_wr_start) begin
          w_next_state = (SETTLE == 0) ? WR_ISSUE : WR_SETTLE;
        end else if (r_rd_start) begin
          w_next_state = (SETTLE == 0) ? RD_ISSUE : RD_SETTLE;
        end
      end
      WR_SETTLE: begin
        if (w_cen_s) begin
          w_next_state = IDLE;
        end else if (r_settle_cnt == SETTLE_LAST) begin
          w_next_state = WR_ISSUE;
        end
      end
      WR_ISSUE: w_next_state = WAIT_CEN;
      RD_SETTLE: begin
        if (w_cen_s) begin
          w_next_state = IDLE;
        end else if (r_settle_cnt == SETTLE_LAST) begin
          w_next_state = RD_ISSUE;
        end
      end
      RD_ISSUE: w_next_state = RD_WAIT;
      RD_WAIT: begin
        if (w_cen_s) begin
          w_next_state = IDLE;
        end else if (dpram_rvalid || w_timeout) begin
          w_next_state = RD_DRIVE;
        end
      end
      RD_DRIVE: begin
        if (w_oen_s || w_cen_s) begin
          w_next_state = IDLE;
        end
      end
      WAIT_CEN: begin
        if (r_err_start) begin
          w_next_state = WAIT_CEN;
        end else if (r_wr_start) begin
          w_next_state = (SETTLE == 0) ? WR_ISSUE : WR_SETTLE;
        end else if (w_cen_s || (w_wen_s && w_oen_s)) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Output logic; address, data and mask hold unless an access updates them
  always_comb begin
    w_dpram_wen    = 1'b0;
    w_dpram_ren    = 1'b0;
    w_dpram_addr   = r_dpram_addr;
    w_dpram_wdata  = r_dpram_wdata;
    w_dpram_be     = r_dpram_be;
    w_emif_data_o  = r_emif_data_o;
    w_emif_data_oe = 1'b0;
    w_err_pulse    = 1'b0;
    case (r_state)
      IDLE, WAIT_CEN: begin
        w_err_pulse = r_err_start;
      end
      WR_ISSUE: begin
        w_dpram_wen   = 1'b1;
        w_dpram_addr  = w_addr_map;
        w_dpram_wdata = w_data_s;
        w_dpram_be    = ~w_byten_s;
      end
      RD_ISSUE: begin
        w_dpram_ren  = 1'b1;
        w_dpram_addr = w_addr_map;
        w_dpram_be   = ~w_byten_s;
      end
      RD_WAIT: begin
        if (!w_cen_s) begin
          if (dpram_rvalid) begin
            w_emif_data_o = dpram_rdata;
          end else if (w_timeout) begin
            w_emif_data_o = '0;
            w_err_pulse   = 1'b1;
          end
        end
      end
      RD_DRIVE: begin
        w_emif_data_oe = ~w_oen_s & ~w_cen_s;
      end
      default: begin
      end
    endcase
  end

  // Output registers
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      r_dpram_wen    <= 1'b0;
      r_dpram_ren    <= 1'b0;
      r_dpram_addr   <= '0;
      r_dpram_wdata  <= '0;
      r_dpram_be     <= '0;
      r_emif_data_o  <= '0;
      r_emif_data_oe <= 1'b0;
      r_err_pulse    <= 1'b0;
    end else begin
      r_dpram_wen    <= w_dpram_wen;
      r_dpram_ren    <= w_dpram_ren;
      r_dpram_addr   <= w_dpram_addr;
      r_dpram_wdata  <= w_dpram_wdata;
      r_dpram_be     <= w_dpram_be;
      r_emif_data_o  <= w_emif_data_o;
      r_emif_data_oe <= w_emif_data_oe;
      r_err_pulse    <= w_err_pulse;
    end
  end

  // Settle and timeout counters run only while the FSM remains in the
  // owning state and clear whenever it leaves
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      r_settle_cnt <= '0;
      r_to_cnt     <= '0;
    end else begin
      if ((r_state == WR_SETTLE || r_state == RD_SETTLE) && w_next_state == r_state) begin
        r_settle_cnt <= r_settle_cnt + 3'd1;
      end else begin
        r_settle_cnt <= '0;
      end
      if (r_state == RD_WAIT && w_next_state == RD_WAIT) begin
        r_to_cnt <= r_to_cnt + 8'd1;
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

  assign dpram_wen    = r_dpram_wen;
  assign dpram_ren    = r_dpram_ren;
  assign dpram_addr   = r_dpram_addr;
  assign dpram_wdata  = r_dpram_wdata;
  assign dpram_be     = r_dpram_be;
  assign emif_data_o  = r_emif_data_o;
  assign emif_data_oe = r_emif_data_oe;
  assign err_pulse    = r_err_pulse;

endmodule

// File: tb/tb_emif_intf_param.sv
// -----------------------------------------------------------------------------
// tb_emif_intf_param
//
// Self-checking bench for emif_intf_param with default parameters. Expected
// DPRAM transactions are queued when the EMIF stimulus is driven and are
// popped when the DUT issues the matching strobe.
// -----------------------------------------------------------------------------
module tb_emif_intf_param;

  localparam int DW   = 16;
  localparam int AW   = 24;
  localparam int BW   = DW / 8;
  localparam int SYNC = 2;
  localparam int SET  = 1;
  localparam int TO   = 15;

  logic          clk_100m = 1'b0;
  logic          rst_n = 1'b1;
  logic [DW-1:0] emif_data_i;
  logic [AW-1:0] emif_addr_i;
  logic [BW-1:0] emif_byten_i;
  logic          emif_cen_i;
  logic          emif_wen_i;
  logic          emif_oen_i;
  logic [DW-1:0] emif_data_o;
  logic          emif_data_oe;
  logic          dpram_wen;
  logic          dpram_ren;
  logic [AW-1:0] dpram_addr;
  logic [DW-1:0] dpram_wdata;
  logic [BW-1:0] dpram_be;
  logic [DW-1:0] dpram_rdata;
  logic          dpram_rvalid;
  logic          err_pulse;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [BW-1:0] be;
  } exp_t;

  exp_t expQ[$];

  int testsRun = 0;
  int testsFailed = 0;
  int wenCount = 0;
  int renCount = 0;
  int errCount = 0;

  emif_intf_param #(
    .DW(DW), .AW(AW), .SYNC_STAGES(SYNC), .SETTLE(SET), .ADDR_ROT(1), .RD_TIMEOUT(TO)
  ) dut (
    .clk_100m(clk_100m),
    .rst_n(rst_n),
    .emif_data_i(emif_data_i),
    .emif_addr_i(emif_addr_i),
    .emif_byten_i(emif_byten_i),
    .emif_cen_i(emif_cen_i),
    .emif_wen_i(emif_wen_i),
    .emif_oen_i(emif_oen_i),
    .emif_data_o(emif_data_o),
    .emif_data_oe(emif_data_oe),
    .dpram_wen(dpram_wen),
    .dpram_ren(dpram_ren),
    .dpram_addr(dpram_addr),
    .dpram_wdata(dpram_wdata),
    .dpram_be(dpram_be),
    .dpram_rdata(dpram_rdata),
    .dpram_rvalid(dpram_rvalid),
    .err_pulse(err_pulse)
  );

  always #5 clk_100m = ~clk_100m;

  // Strobe counters sampled on the falling edge
  always @(negedge clk_100m) begin
    if (dpram_wen === 1'b1) wenCount++;
    if (dpram_ren === 1'b1) renCount++;
    if (err_pulse === 1'b1) errCount++;
  end

  task automatic busIdle();
    emif_cen_i   = 1'b1;
    emif_wen_i   = 1'b1;
    emif_oen_i   = 1'b1;
    emif_byten_i = '1;
    emif_data_i  = '0;
    emif_addr_i  = '0;
    dpram_rvalid = 1'b0;
    dpram_rdata  = '0;
  endtask

  // Waits up to maxCyc rising edges for a condition; lat is -1 if it never occurs
  // sel: 0 wen, 1 ren, 2 err, 3 oe high, 4 oe low
  task automatic waitFor(input int sel, input int maxCyc, output int lat);
    lat = -1;
    for (int k = 1; k <= maxCyc; k++) begin
      @(posedge clk_100m);
      #1;
      if ((sel == 0 && dpram_wen === 1'b1) || (sel == 1 && dpram_ren === 1'b1) ||
          (sel == 2 && err_pulse === 1'b1) || (sel == 3 && emif_data_oe === 1'b1) ||
          (sel == 4 && emif_data_oe === 1'b0)) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    busIdle();
    #2 rst_n = 1'b0;
    #20;
    testsRun++;
    if ({dpram_wen, dpram_ren, err_pulse, emif_data_oe} !== 4'b0000) begin
      testsFailed++;
      $display("[TB] FAIL reset_strobes: got %b expected 0000", {dpram_wen, dpram_ren, err_pulse, emif_data_oe});
    end
    testsRun++;
    if (dpram_be !== 2'b00) begin
      testsFailed++;
      $display("[TB] FAIL reset_be: got %b expected 00", dpram_be);
    end
    testsRun++;
    if ({dpram_addr, dpram_wdata, emif_data_o} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_buses: got addr %h wdata %h data_o %h expected all 0", dpram_addr, dpram_wdata, emif_data_o);
    end
    @(negedge clk_100m);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_100m);
  endtask

  task automatic test_write();
    exp_t e;
    int lat;
    int w0;
    @(negedge clk_100m);
    emif_addr_i = 24'h800001; emif_data_i = 16'h1234; emif_byten_i = 2'b00;
    emif_cen_i = 1'b0; emif_wen_i = 1'b0;
    e.addr = 24'h000003; e.data = 16'h1234; e.be = 2'b11;
    expQ.push_back(e);
    w0 = wenCount;
    @(posedge clk_100m);
    waitFor(0, 20, lat);
    testsRun++;
    if (lat !== SYNC + SET + 2) begin
      testsFailed++;
      $display("[TB] FAIL write_latency: got %0d expected %0d", lat, SYNC + SET + 2);
    end
    if (expQ.size() == 0) begin
      testsRun++; testsFailed++;
      $display("[TB] FAIL write_scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = expQ.pop_front();
      testsRun++;
      if (dpram_addr !== e.addr) begin
        testsFailed++;
        $display("[TB] FAIL write_addr: got %h expected %h", dpram_addr, e.addr);
      end
      testsRun++;
      if (dpram_wdata !== e.data) begin
        testsFailed++;
        $display("[TB] FAIL write_data: got %h expected %h", dpram_wdata, e.data);
      end
      testsRun++;
      if (dpram_be !== e.be) begin
        testsFailed++;
        $display("[TB] FAIL write_be: got %b expected %b", dpram_be, e.be);
      end
    end
    @(negedge clk_100m);
    emif_wen_i = 1'b1; emif_cen_i = 1'b1;
    repeat (6) @(negedge clk_100m);
    testsRun++;
    if (wenCount - w0 !== 1) begin
      testsFailed++;
      $display("[TB] FAIL write_single_pulse: got %0d wen cycles expected 1", wenCount - w0);
    end
    testsRun++;
    if (dpram_addr !== 24'h000003) begin
      testsFailed++;
      $display("[TB] FAIL write_addr_hold: got %h expected 000003", dpram_addr);
    end
  endtask

  task automatic test_partial_write();
    exp_t e;
    int lat;
    int w0;
    int e0;
    @(negedge clk_100m);
    emif_addr_i = 24'h000100; emif_data_i = 16'hA5A5; emif_byten_i = 2'b10;
    emif_cen_i = 1'b0; emif_wen_i = 1'b0;
    e.addr = 24'h000200; e.data = 16'hA5A5; e.be = 2'b01;
    expQ.push_back(e);
    waitFor(0, 20, lat);
    e = expQ.pop_front();
    testsRun++;
    if (lat < 0 || dpram_be !== e.be || dpram_addr !== e.addr || dpram_wdata !== e.data) begin
      testsFailed++;
      $display("[TB] FAIL partial_write: got lat %0d be %b addr %h data %h expected be %b addr %h data %h",
               lat, dpram_be, dpram_addr, dpram_wdata, e.be, e.addr, e.data);
    end
    @(negedge clk_100m);
    emif_wen_i = 1'b1; emif_cen_i = 1'b1;
    repeat (6) @(negedge clk_100m);
    w0 = wenCount;
    e0 = errCount;
    emif_byten_i = 2'b11; emif_addr_i = 24'h000111;
    emif_cen_i = 1'b0; emif_wen_i = 1'b0;
    repeat (15) @(negedge clk_100m);
    testsRun++;
    if (errCount - e0 !== 1) begin
      testsFailed++;
      $display("[TB] FAIL byten_err_pulse: got %0d err cycles expected 1", errCount - e0);
    end
    testsRun++;
    if (wenCount - w0 !== 0) begin
      testsFailed++;
      $display("[TB] FAIL byten_no_write: got %0d wen cycles expected 0", wenCount - w0);
    end
    emif_wen_i = 1'b1; emif_cen_i = 1'b1;
    repeat (6) @(negedge clk_100m);
  endtask

  task automatic test_read();
    exp_t e;
    int lat;
    @(negedge clk_100m);
    emif_addr_i = 24'h000010; emif_byten_i = 2'b00;
    emif_cen_i = 1'b0; emif_oen_i = 1'b0;
    e.addr = 24'h000020; e.data = 16'hBEEF; e.be = 2'b11;
    expQ.push_back(e);
    waitFor(1, 20, lat);
    e = expQ.pop_front();
    testsRun++;
    if (lat < 0 || dpram_addr !== e.addr || dpram_be !== e.be) begin
      testsFailed++;
      $display("[TB] FAIL read_issue: got lat %0d addr %h be %b expected addr %h be %b", lat, dpram_addr, dpram_be, e.addr, e.be);
    end
    @(posedge clk_100m);
    @(posedge clk_100m);
    #1 dpram_rvalid = 1'b1; dpram_rdata = e.data;
    @(posedge clk_100m);
    #1 dpram_rvalid = 1'b0; dpram_rdata = '0;
    waitFor(3, 10, lat);
    testsRun++;
    if (lat < 0 || emif_data_o !== e.data) begin
      testsFailed++;
      $display("[TB] FAIL read_data: got lat %0d data %h expected %h", lat, emif_data_o, e.data);
    end
    // Stray rvalid outside the wait phase must not disturb the returned data
    @(negedge clk_100m);
    dpram_rvalid = 1'b1; dpram_rdata = 16'h1111;
    @(negedge clk_100m);
    dpram_rvalid = 1'b0; dpram_rdata = '0;
    repeat (2) @(negedge clk_100m);
    testsRun++;
    if (emif_data_o !== 16'hBEEF || emif_data_oe !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL read_hold: got data %h oe %b expected BEEF 1", emif_data_o, emif_data_oe);
    end
    @(negedge clk_100m);
    emif_oen_i = 1'b1;
    @(posedge clk_100m);
    waitFor(4, 10, lat);
    testsRun++;
    if (lat !== SYNC) begin
      testsFailed++;
      $display("[TB] FAIL read_oe_drop: got %0d cycles expected %0d", lat, SYNC);
    end
    @(negedge clk_100m);
    emif_cen_i = 1'b1;
    repeat (4) @(negedge clk_100m);
  endtask

  task automatic test_timeout();
    int lat;
    @(negedge clk_100m);
    emif_addr_i = 24'h000040; emif_byten_i = 2'b00;
    emif_cen_i = 1'b0; emif_oen_i = 1'b0;
    waitFor(1, 20, lat);
    testsRun++;
    if (lat < 0 || dpram_addr !== 24'h000080) begin
      testsFailed++;
      $display("[TB] FAIL timeout_ren: got lat %0d addr %h expected addr 000080", lat, dpram_addr);
    end
    waitFor(2, 40, lat);
    testsRun++;
    if (lat !== TO + 1) begin
      testsFailed++;
      $display("[TB] FAIL timeout_latency: got %0d expected %0d", lat, TO + 1);
    end
    testsRun++;
    if (emif_data_o !== 16'h0000) begin
      testsFailed++;
      $display("[TB] FAIL timeout_data: got %h expected 0000", emif_data_o);
    end
    @(posedge clk_100m);
    #1;
    testsRun++;
    if (emif_data_oe !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL timeout_oe: got %b expected 1", emif_data_oe);
    end
    @(negedge clk_100m);
    emif_oen_i = 1'b1;
    waitFor(4, 10, lat);
    @(negedge clk_100m);
    emif_cen_i = 1'b1;
    repeat (4) @(negedge clk_100m);
  endtask

  task automatic test_abort_reset();
    int lat;
    int w0;
    @(negedge clk_100m);
    emif_addr_i = 24'h000300; emif_data_i = 16'h7777; emif_byten_i = 2'b00;
    emif_cen_i = 1'b0; emif_wen_i = 1'b0;
    w0 = wenCount;
    @(posedge clk_100m);
    @(posedge clk_100m);
    @(negedge clk_100m);
    emif_cen_i = 1'b1; emif_wen_i = 1'b1;
    repeat (15) @(negedge clk_100m);
    testsRun++;
    if (wenCount - w0 !== 0) begin
      testsFailed++;
      $display("[TB] FAIL abort_no_write: got %0d wen cycles expected 0", wenCount - w0);
    end
    testsRun++;
    if (dpram_addr !== 24'h000080) begin
      testsFailed++;
      $display("[TB] FAIL abort_addr_hold: got %h expected 000080", dpram_addr);
    end
    emif_addr_i = 24'h000008; emif_cen_i = 1'b0; emif_oen_i = 1'b0;
    waitFor(1, 20, lat);
    #3 rst_n = 1'b0;
    #1;
    testsRun++;
    if (lat < 0 || dpram_be !== 2'b00 || dpram_addr !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_mid_read: got lat %0d be %b addr %h expected be 00 addr 000000", lat, dpram_be, dpram_addr);
    end
    testsRun++;
    if ({dpram_wen, dpram_ren, err_pulse, emif_data_oe, emif_data_o, dpram_wdata} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_mid_read_outputs: got wen %b ren %b err %b oe %b data_o %h wdata %h expected all 0",
               dpram_wen, dpram_ren, err_pulse, emif_data_oe, emif_data_o, dpram_wdata);
    end
    busIdle();
    @(negedge clk_100m);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_100m);
    emif_addr_i = 24'h000005; emif_byten_i = 2'b00; emif_cen_i = 1'b0; emif_oen_i = 1'b0;
    waitFor(1, 20, lat);
    testsRun++;
    if (lat < 0 || dpram_addr !== 24'h00000A) begin
      testsFailed++;
      $display("[TB] FAIL post_reset_ren: got lat %0d addr %h expected 00000a", lat, dpram_addr);
    end
    dpram_rvalid = 1'b1; dpram_rdata = 16'h1357;
    @(posedge clk_100m);
    #1 dpram_rvalid = 1'b0; dpram_rdata = '0;
    waitFor(3, 10, lat);
    testsRun++;
    if (lat < 0 || emif_data_o !== 16'h1357) begin
      testsFailed++;
      $display("[TB] FAIL post_reset_read: got lat %0d data %h expected 1357", lat, emif_data_o);
    end
    @(negedge clk_100m);
    emif_oen_i = 1'b1;
    waitFor(4, 10, lat);
    @(negedge clk_100m);
    emif_cen_i = 1'b1;
    repeat (4) @(negedge clk_100m);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int pulses;
    int w0;
    int r0;
    int e0;
    pulses = 0;
    @(negedge clk_100m);
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc == 0) begin
        emif_cen_i = 1'b0; emif_wen_i = 1'b0;
        emif_addr_i = 24'h400002; emif_data_i = 16'hCAFE; emif_byten_i = 2'b00;
        e.addr = 24'h800004; e.data = 16'hCAFE; e.be = 2'b11;
        expQ.push_back(e);
      end else if (cyc == 4) begin
        emif_wen_i = 1'b1;
      end else if (cyc == 10) begin
        emif_wen_i = 1'b0;
        emif_addr_i = 24'hC00010; emif_data_i = 16'h0F0F; emif_byten_i = 2'b01;
        e.addr = 24'h800021; e.data = 16'h0F0F; e.be = 2'b10;
        expQ.push_back(e);
      end else if (cyc == 14) begin
        emif_wen_i = 1'b1;
      end
      @(posedge clk_100m);
      #1;
      if (dpram_wen === 1'b1) begin
        pulses++;
        if (expQ.size() == 0) begin
          testsRun++; testsFailed++;
          $display("[TB] FAIL b2b_unexpected_write: got addr %h with empty scoreboard", dpram_addr);
        end else begin
          e = expQ.pop_front();
          testsRun++;
          if (dpram_addr !== e.addr || dpram_wdata !== e.data || dpram_be !== e.be) begin
            testsFailed++;
            $display("[TB] FAIL b2b_write: got addr %h data %h be %b expected addr %h data %h be %b",
                     dpram_addr, dpram_wdata, dpram_be, e.addr, e.data, e.be);
          end
        end
      end
    end
    testsRun++;
    if (pulses !== 2 || expQ.size() !== 0) begin
      testsFailed++;
      $display("[TB] FAIL b2b_count: got %0d pulses %0d pending expected 2 pulses 0 pending", pulses, expQ.size());
    end
    expQ.delete();
    @(negedge clk_100m);
    emif_cen_i = 1'b1;
    repeat (5) @(negedge clk_100m);
    w0 = wenCount;
    r0 = renCount;
    e0 = errCount;
    emif_byten_i = 2'b00; emif_cen_i = 1'b0; emif_wen_i = 1'b0; emif_oen_i = 1'b0;
    repeat (12) @(negedge clk_100m);
    testsRun++;
    if (errCount - e0 !== 1) begin
      testsFailed++;
      $display("[TB] FAIL both_fall_err: got %0d err cycles expected 1", errCount - e0);
    end
    testsRun++;
    if (wenCount - w0 !== 0 || renCount - r0 !== 0) begin
      testsFailed++;
      $display("[TB] FAIL both_fall_no_strobe: got wen %0d ren %0d expected 0 0", wenCount - w0, renCount - r0);
    end
    busIdle();
    repeat (5) @(negedge clk_100m);
  endtask

  initial begin
    test_reset();
    test_write();
    test_partial_write();
    test_read();
    test_timeout();
    test_abort_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion expected finish before 200000ns");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
